// File: rtl/regs_pkg.sv
// Shared constants for the integer register file.
//   XLEN        - register width in bits
//   REG_NUM     - number of architectural registers (x0..x31)
//   REG_ADDR_W  - register address width
//   ZERO_WORD   - all-zero data word (x0 value, reset value)
package regs_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regs_rport.sv
// Combinational read port of the integer register file.
// Ports:
//   rst_i     - synchronous reset of the core; forces the output to zero
//   raddr_i   - read address
//   wen_i     - write-back enable (for bypass)
//   waddr_i   - write-back address (for bypass)
//   wdata_i   - write-back data (for bypass)
//   rf_i      - flattened storage, x1 in the lowest XLEN bits, no x0 slot
//   rdata_o   - read data
// Priority: reset -> x0 -> write-back bypass -> stored value.
module regs_rport
  import regs_pkg::*;
#(
  parameter int unsigned Xlen   = XLEN,
  parameter int unsigned RegNum = REG_NUM
) (
  input  logic                         rst_i,
  input  logic [REG_ADDR_W-1:0]        raddr_i,
  input  logic                         wen_i,
  input  logic [REG_ADDR_W-1:0]        waddr_i,
  input  logic [Xlen-1:0]              wdata_i,
  input  logic [(RegNum-1)*Xlen-1:0]   rf_i,
  output logic [Xlen-1:0]              rdata_o
);

  logic [Xlen-1:0] arr_rdata;

  // Array read mux; x0 has no slot so it falls through to zero here too.
  always_comb begin
    arr_rdata = '0;
    for (int i = 1; i < int'(RegNum); i++) begin
      if (raddr_i == REG_ADDR_W'(i)) begin
        arr_rdata = rf_i[(i-1)*int'(Xlen) +: Xlen];
      end
    end
  end

  // Bypass is the last 2:1 mux ahead of the zero-forcing, keeping the
  // execute -> decode path short.
  always_comb begin
    rdata_o = arr_rdata;
    if (rst_i || (raddr_i == '0)) begin
      rdata_o = '0;
    end else if (wen_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/regs.sv
// RV32 integer register file: 31 stored registers (x1..x31), x0 hard-wired
// to zero, two decode read ports and one debug read port, all with
// same-cycle write-back bypass.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   reg_wen_i/waddr_i/wdata_i   - write-back from the execute stage
//   reg1_raddr_i/reg1_rdata_o   - decode rs1 read port
//   reg2_raddr_i/reg2_rdata_o   - decode rs2 read port
//   dbg_raddr_i/dbg_rdata_o     - debug/difftest read port
module regs
  import regs_pkg::*;
#(
  parameter int unsigned XLEN    = regs_pkg::XLEN,
  parameter int unsigned REG_NUM = regs_pkg::REG_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_wen_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  input  logic [REG_ADDR_W-1:0] reg1_raddr_i,
  output logic [XLEN-1:0]       reg1_rdata_o,
  input  logic [REG_ADDR_W-1:0] reg2_raddr_i,
  output logic [XLEN-1:0]       reg2_rdata_o,
  input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
  output logic [XLEN-1:0]       dbg_rdata_o
);

  localparam int unsigned StoreW = (REG_NUM - 1) * XLEN;

  logic [StoreW-1:0] regs_q, regs_d;

  // Writes to x0 match no slot and are dropped.
  always_comb begin
    regs_d = regs_q;
    if (reg_wen_i) begin
      for (int i = 1; i < int'(REG_NUM); i++) begin
        if (reg_waddr_i == REG_ADDR_W'(i)) begin
          regs_d[(i-1)*int'(XLEN) +: XLEN] = reg_wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regs_rport #(
    .Xlen   (XLEN),
    .RegNum (REG_NUM)
  ) u_rport1 (
    .rst_i   (rst),
    .raddr_i (reg1_raddr_i),
    .wen_i   (reg_wen_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .rf_i    (regs_q),
    .rdata_o (reg1_rdata_o)
  );

  regs_rport #(
    .Xlen   (XLEN),
    .RegNum (REG_NUM)
  ) u_rport2 (
    .rst_i   (rst),
    .raddr_i (reg2_raddr_i),
    .wen_i   (reg_wen_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .rf_i    (regs_q),
    .rdata_o (reg2_rdata_o)
  );

  regs_rport #(
    .Xlen   (XLEN),
    .RegNum (REG_NUM)
  ) u_rport_dbg (
    .rst_i   (rst),
    .raddr_i (dbg_raddr_i),
    .wen_i   (reg_wen_i),
    .waddr_i (reg_waddr_i),
    .wdata_i (reg_wdata_i),
    .rf_i    (regs_q),
    .rdata_o (dbg_rdata_o)
  );

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for the integer register file: a table of per-cycle
// vectors followed by hand-written multi-cycle sequences.
module tb_regs;

  logic        clk;
  logic        rst;
  logic        reg_wen_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic [4:0]  reg1_raddr_i;
  logic [31:0] reg1_rdata_o;
  logic [4:0]  reg2_raddr_i;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;

  int total;
  int bad;

  regs dut (
    .clk          (clk),
    .rst          (rst),
    .reg_wen_i    (reg_wen_i),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg1_raddr_i (reg1_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_raddr_i (reg2_raddr_i),
    .reg2_rdata_o (reg2_rdata_o),
    .dbg_raddr_i  (dbg_raddr_i),
    .dbg_rdata_o  (dbg_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [4:0]  dba;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] a1, logic [4:0] a2, logic [4:0] ad,
                              logic [31:0] x1, logic [31:0] x2, logic [31:0] xd);
    vec_t v;
    v.rst = r; v.wen = w; v.waddr = wa; v.wdata = wd;
    v.r1a = a1; v.r2a = a2; v.dba = ad;
    v.e1 = x1; v.e2 = x2; v.ed = xd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad);
    rst = r; reg_wen_i = w; reg_waddr_i = wa; reg_wdata_i = wd;
    reg1_raddr_i = a1; reg2_raddr_i = a2; dbg_raddr_i = ad;
  endtask

  function automatic logic [31:0] pat(int i);
    logic [31:0] p;
    p = (32'(i) * 32'h0101_0101) ^ 32'hC3C3_0000;
    return p;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // rst wen waddr wdata        r1 r2 dbg  exp1          exp2          expd
    vecs.push_back(mk(1, 0, 0,  32'h0,         5,  3,  7,  0,            0,            0));
    vecs.push_back(mk(0, 1, 5,  32'hDEAD_BEEF, 5,  0,  5,  32'hDEAD_BEEF, 0,           32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0, 5,  32'h0,         5,  5,  4,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0));
    // reset together with a write to x3: everything reads zero
    vecs.push_back(mk(1, 1, 3,  32'hAA,        5,  3,  3,  0,            0,            0));
    vecs.push_back(mk(0, 0, 3,  32'hAA,        5,  3,  3,  0,            0,            0));
    vecs.push_back(mk(0, 1, 10, 32'h1234_5678, 10, 10, 10, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678));
    vecs.push_back(mk(0, 0, 10, 32'h0,         10, 10, 5,  32'h1234_5678, 32'h1234_5678, 0));
    // x0 write: no bypass, no storage
    vecs.push_back(mk(0, 1, 0,  32'hFFFF_FFFF, 0,  0,  0,  0,            0,            0));
    vecs.push_back(mk(0, 0, 0,  32'hFFFF_FFFF, 0,  0,  0,  0,            0,            0));
    // bypass on x7
    vecs.push_back(mk(0, 1, 7,  32'h1,         7,  7,  7,  32'h1,        32'h1,        32'h1));
    vecs.push_back(mk(0, 1, 7,  32'h2,         7,  7,  6,  32'h2,        32'h2,        0));
    vecs.push_back(mk(0, 0, 7,  32'h2,         7,  7,  7,  32'h2,        32'h2,        32'h2));
    vecs.push_back(mk(0, 1, 7,  32'h1,         10, 7,  7,  32'h1234_5678, 32'h1,       32'h1));
    vecs.push_back(mk(0, 0, 7,  32'h2,         7,  7,  10, 32'h1,        32'h1,        32'h1234_5678));
    // back-to-back x1/x2/x1
    vecs.push_back(mk(0, 1, 1,  32'h1,         1,  2,  1,  32'h1,        0,            32'h1));
    vecs.push_back(mk(0, 1, 2,  32'h2,         1,  2,  2,  32'h1,        32'h2,        32'h2));
    vecs.push_back(mk(0, 1, 1,  32'h3,         1,  2,  1,  32'h3,        32'h2,        32'h3));
    vecs.push_back(mk(0, 0, 1,  32'h0,         1,  2,  1,  32'h3,        32'h2,        32'h3));
    vecs.push_back(mk(0, 0, 1,  32'h0,         1,  1,  2,  32'h3,        32'h3,        32'h2));

    @(posedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].wen, vecs[k].waddr, vecs[k].wdata,
            vecs[k].r1a, vecs[k].r2a, vecs[k].dba);
      #2;
      check($sformatf("vec%0d.reg1", k), reg1_rdata_o, vecs[k].e1);
      check($sformatf("vec%0d.reg2", k), reg2_rdata_o, vecs[k].e2);
      check($sformatf("vec%0d.dbg", k),  dbg_rdata_o,  vecs[k].ed);
    end

    // Fill x1..x31 with distinct patterns, read all back on the debug port.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 5'(i), pat(i), 5'd0, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr_i  = 5'(i);
      reg1_raddr_i = 5'(31 - i);
      #1;
      check($sformatf("fill.dbg[%0d]", i), dbg_rdata_o, (i == 0) ? 32'h0 : pat(i));
      check($sformatf("fill.reg1[%0d]", 31 - i), reg1_rdata_o,
            (i == 31) ? 32'h0 : pat(31 - i));
    end

    // One-cycle reset pulse clears every register.
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0);
    #2;
    check("rst.hold.reg1", reg1_rdata_o, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd0);
    #1;
    check("rst.after.reg1", reg1_rdata_o, 32'h0);
    check("rst.after.reg2", reg2_rdata_o, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr_i = 5'(i);
      #1;
      check($sformatf("rst.dbg[%0d]", i), dbg_rdata_o, 32'h0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
